pipelined_instr_decoder: RTL and testbench
==========================================

PIPELINED_INSTR_DECODER -- requirements
Module: pipelined_instr_decoder

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width for PC and immediate; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream instruction/PC valid.
REQ-005 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-006 SHALL have port in_instr  input  32  raw RV32/RV64 base instruction.
REQ-007 SHALL have port in_pc  input  XLEN  PC of in_instr.
REQ-008 SHALL have port flush  input  1  discard all held entries.
REQ-009 SHALL have port out_valid  output  1  decoded entry available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have outputs op_code 7, rd 5, fun3 3, rs1 5, rs2 5, fun7 7, sliced from bits [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
REQ-012 SHALL have outputs out_pc XLEN, imm XLEN (sign-extended immediate), fmt 3 (format code), illegal 1.

Function
REQ-013 SHALL hold decoded entries in a 2-entry elastic buffer (main + skid); all outputs driven from main entry registers, with no combinational path from in_* to out_*.
REQ-014 SHALL decode fully at capture time; an accepted entry appears on outputs the next cycle (latency 1).
REQ-015 in_ready SHALL be a registered signal equal to "skid entry empty"; no combinational dependence on out_ready.
REQ-016 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready; simultaneous input and output transfers in one cycle SHALL sustain throughput of 1/cycle.
REQ-017 When main is full, out_ready=0 and input accepted, the entry SHALL go to skid; when main drains, skid SHALL move to main in the same edge; order strictly FIFO.
REQ-018 fmt encoding: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-019 Opcode map: 0110011/0111011 R; 0010011/0011011/0000011/1100111/1110011/0001111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; any other opcode, or in_instr[1:0]!=2'b11, ILL.
REQ-020 imm SHALL be: I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; U {instr[31:12],12'b0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; each sign-extended from instr[31] to XLEN; R and ILL give imm=0.
REQ-021 illegal SHALL be 1 exactly when fmt=ILL; illegal entries still flow through the buffer normally.
REQ-022 flush SHALL empty both entries at the next edge (out_valid=0, in_ready=1); an input presented in the flush cycle SHALL be dropped; flush has priority over all transfers.
REQ-023 Field outputs, out_pc, imm, fmt, illegal SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-024 On rst_n=0, asynchronously: out_valid=0, in_ready=1, both entries invalid, all data outputs 0, fmt=0, illegal=0.
REQ-025 Reset asserted mid-operation SHALL discard held entries; first accept after rst_n release is permitted on the first rising edge.

Structure
REQ-026 Opcode constants and fmt encoding SHALL live in shared package decode_pkg, reused by later pipeline stages.
REQ-027 Immediate generation SHALL be a combinational sub-module imm_gen (inputs instr, fmt; output imm; parameter XLEN).

Verification
REQ-028 XLEN=32: in_instr=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, fun3=0, fmt=1, imm=0xFFFFFFFF, illegal=0.
REQ-029 in_instr=0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC; in_instr=0x123452B7 (lui x5) -> fmt=4, rd=5, imm=0x12345000.
REQ-030 out_ready=0, send A,B,C on consecutive cycles -> A,B accepted, in_ready=0 from cycle after B; raise out_ready -> A,B,C emitted in order, no loss or duplication.
REQ-031 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-032 in_instr=0x00000000 -> illegal=1, fmt=7, imm=0; XLEN=64 with 0xFFF10093 -> imm=0xFFFFFFFFFFFFFFFF.
REQ-033 rst_n pulsed low mid-stream with entries held -> out_valid=0 immediately (asynchronously), in_ready=1, no held entry emitted after release.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, format encoding and format decode shared by pipeline stages
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    // Compressed encodings (instr[1:0] != 2'b11) are not supported and decode as illegal.
    function automatic fmt_e decode_fmt(input logic [31:0] instr);
        fmt_e f;
        f = FMT_ILL;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OP_OP, OP_OP_32:                      f = FMT_R;
                OP_IMM, OP_IMM_32, OP_LOAD,
                OP_JALR, OP_SYSTEM, OP_MISC_MEM:      f = FMT_I;
                OP_STORE:                             f = FMT_S;
                OP_BRANCH:                            f = FMT_B;
                OP_LUI, OP_AUIPC:                     f = FMT_U;
                OP_JAL:                               f = FMT_J;
                default:                              f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate generation for each instruction format
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // Assemble the 32-bit immediate for the format; R and illegal yield zero.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/pipelined_instr_decoder.sv
// pipelined_instr_decoder: full decode at capture into a main+skid elastic buffer, outputs from main registers
module pipelined_instr_decoder
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      op_code,
    output logic [4:0]      rd,
    output logic [2:0]      fun3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      fun7,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    fmt_e            in_fmt;
    logic [XLEN-1:0] in_imm;

    logic            m_valid, s_valid;
    logic [31:0]     m_instr, s_instr;
    logic [XLEN-1:0] m_pc, s_pc, m_imm, s_imm;
    fmt_e            m_fmt, s_fmt;

    logic in_fire, m_load, s_load;

    assign in_fmt = decode_fmt(in_instr);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (in_fmt),
        .imm   (in_imm)
    );

    // in_ready is the skid-empty flag itself, so it never depends on out_ready.
    assign in_ready = !s_valid;
    assign in_fire  = in_valid && in_ready;
    // Main refills whenever it is empty or draining; skid catches an input when main stalls.
    assign m_load   = !flush && (!m_valid || out_ready);
    assign s_load   = !flush && in_fire && m_valid && !out_ready;

    // Main entry: refill from skid first (FIFO order), otherwise from the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_instr <= '0;
            m_pc    <= '0;
            m_imm   <= '0;
            m_fmt   <= FMT_R;
        end else begin
            m_valid <= flush ? 1'b0 : m_load ? (s_valid || in_fire) : m_valid;
            if (m_load && (s_valid || in_fire)) begin
                m_instr <= s_valid ? s_instr : in_instr;
                m_pc    <= s_valid ? s_pc    : in_pc;
                m_imm   <= s_valid ? s_imm   : in_imm;
                m_fmt   <= s_valid ? s_fmt   : in_fmt;
            end
        end
    end

    // Skid entry: fills on a stalled accept, empties when it moves to main or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_instr <= '0;
            s_pc    <= '0;
            s_imm   <= '0;
            s_fmt   <= FMT_R;
        end else begin
            s_valid <= flush ? 1'b0 : m_load ? 1'b0 : s_load ? 1'b1 : s_valid;
            if (s_load) begin
                s_instr <= in_instr;
                s_pc    <= in_pc;
                s_imm   <= in_imm;
                s_fmt   <= in_fmt;
            end
        end
    end

    assign out_valid = m_valid;
    assign op_code   = m_instr[6:0];
    assign rd        = m_instr[11:7];
    assign fun3      = m_instr[14:12];
    assign rs1       = m_instr[19:15];
    assign rs2       = m_instr[24:20];
    assign fun7      = m_instr[31:25];
    assign out_pc    = m_pc;
    assign imm       = m_imm;
    assign fmt       = m_fmt;
    assign illegal   = (m_fmt == FMT_ILL);

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// tb_pipelined_instr_decoder: directed self-checking bench for the decoder buffer, XLEN 32 and 64
module tb_pipelined_instr_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid, illegal;
    logic [6:0]  op_code, fun7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  fun3, fmt;
    logic [31:0] out_pc, imm;

    logic        in_ready_w, out_valid_w, illegal_w;
    logic [6:0]  op_code_w, fun7_w;
    logic [4:0]  rd_w, rs1_w, rs2_w;
    logic [2:0]  fun3_w, fmt_w;
    logic [63:0] out_pc_w, imm_w;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipelined_instr_decoder #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .op_code(op_code), .rd(rd), .fun3(fun3), .rs1(rs1),
        .rs2(rs2), .fun7(fun7), .out_pc(out_pc), .imm(imm), .fmt(fmt), .illegal(illegal)
    );

    pipelined_instr_decoder #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_instr(in_instr), .in_pc(in_pc64), .flush(flush), .out_valid(out_valid_w),
        .out_ready(out_ready), .op_code(op_code_w), .rd(rd_w), .fun3(fun3_w), .rs1(rs1_w),
        .rs2(rs2_w), .fun7(fun7_w), .out_pc(out_pc_w), .imm(imm_w), .fmt(fmt_w), .illegal(illegal_w)
    );

    // Present one instruction at a negedge, let one posedge pass, return at the next negedge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_pc64  = {32'hFFFF_0000, pc};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_pc64 = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
        total++; if ({rd, rs1, rs2, fun3, fun7, op_code} !== 32'h0) $display("FAIL reset_fields got %h want 0", {rd, rs1, rs2, fun3, fun7, op_code}); else passed++;
        total++; if ({imm, out_pc} !== 64'h0) $display("FAIL reset_imm_pc got %h want 0", {imm, out_pc}); else passed++;
        total++; if ({fmt, illegal} !== 4'h0) $display("FAIL reset_fmt_illegal got %h want 0", {fmt, illegal}); else passed++;
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        send(32'hFFF10093, 32'h8000_0000);
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0b want 1", out_valid); else passed++;
        total++; if ({rd, rs1, fun3} !== {5'd1, 5'd2, 3'd0}) $display("FAIL addi_fields got rd=%0d rs1=%0d f3=%0d want 1 2 0", rd, rs1, fun3); else passed++;
        total++; if ({fmt, illegal} !== {3'd1, 1'b0}) $display("FAIL addi_fmt got fmt=%0d ill=%0b want 1 0", fmt, illegal); else passed++;
        total++; if (imm !== 32'hFFFFFFFF) $display("FAIL addi_imm got %h want ffffffff", imm); else passed++;
        total++; if (out_pc !== 32'h8000_0000) $display("FAIL addi_pc got %h want 80000000", out_pc); else passed++;
        total++; if (imm_w !== 64'hFFFFFFFF_FFFFFFFF) $display("FAIL addi_imm64 got %h want ffffffffffffffff", imm_w); else passed++;
        total++; if (out_pc_w !== 64'hFFFF0000_80000000) $display("FAIL addi_pc64 got %h want ffff000080000000", out_pc_w); else passed++;
        send(32'hFE000EE3, 32'h8000_0004);
        total++; if ({fmt, imm} !== {3'd3, 32'hFFFFFFFC}) $display("FAIL beq got fmt=%0d imm=%h want 3 fffffffc", fmt, imm); else passed++;
        send(32'h123452B7, 32'h8000_0008);
        total++; if ({fmt, rd, imm} !== {3'd4, 5'd5, 32'h12345000}) $display("FAIL lui got fmt=%0d rd=%0d imm=%h want 4 5 12345000", fmt, rd, imm); else passed++;
        total++; if ({fmt_w, imm_w} !== {3'd4, 64'h00000000_12345000}) $display("FAIL lui64 got fmt=%0d imm=%h want 4 12345000", fmt_w, imm_w); else passed++;
        send(32'h00000000, 32'h8000_000C);
        total++; if ({illegal, fmt, imm} !== {1'b1, 3'd7, 32'h0}) $display("FAIL zero_ill got ill=%0b fmt=%0d imm=%h want 1 7 0", illegal, fmt, imm); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL zero_valid got %0b want 1", out_valid); else passed++;
        send(32'h00A5A023, 32'h8000_0010);
        total++; if ({fmt, imm, rs1, rs2} !== {3'd2, 32'h0, 5'd11, 5'd10}) $display("FAIL sw got fmt=%0d imm=%h rs1=%0d rs2=%0d want 2 0 11 10", fmt, imm, rs1, rs2); else passed++;
        send(32'hFE5A8FA3, 32'h8000_0014);
        total++; if ({fmt, imm} !== {3'd2, 32'hFFFFFFFF}) $display("FAIL sb_neg got fmt=%0d imm=%h want 2 ffffffff", fmt, imm); else passed++;
        send(32'hFF9FF0EF, 32'h8000_0018);
        total++; if ({fmt, rd, imm} !== {3'd5, 5'd1, 32'hFFFFFFF8}) $display("FAIL jal got fmt=%0d rd=%0d imm=%h want 5 1 fffffff8", fmt, rd, imm); else passed++;
        send(32'h40B50533, 32'h8000_001C);
        total++; if ({fmt, fun7, imm, illegal} !== {3'd0, 7'h20, 32'h0, 1'b0}) $display("FAIL sub got fmt=%0d f7=%h imm=%h ill=%0b want 0 20 0 0", fmt, fun7, imm, illegal); else passed++;
        send(32'hFFF10092, 32'h8000_0020);
        total++; if ({illegal, fmt, imm} !== {1'b1, 3'd7, 32'h0}) $display("FAIL low_bits_ill got ill=%0b fmt=%0d imm=%h want 1 7 0", illegal, fmt, imm); else passed++;
        idle_cycle();
        total++; if (out_valid !== 1'b0) $display("FAIL decode_drain got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        send(32'h00100093, 32'h100);
        total++; if (in_ready !== 1'b1) $display("FAIL skid_ready_after_a got %0b want 1", in_ready); else passed++;
        send(32'h00200113, 32'h104);
        total++; if (in_ready !== 1'b0) $display("FAIL skid_ready_after_b got %0b want 0", in_ready); else passed++;
        send(32'h00300193, 32'h108);
        total++; if ({out_valid, rd, out_pc} !== {1'b1, 5'd1, 32'h100}) $display("FAIL skid_hold_a got v=%0b rd=%0d pc=%h want 1 1 100", out_valid, rd, out_pc); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL skid_c_blocked got %0b want 0", in_ready); else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if ({out_valid, rd, imm, out_pc} !== {1'b1, 5'd2, 32'd2, 32'h104}) $display("FAIL skid_out_b got v=%0b rd=%0d imm=%h pc=%h want 1 2 2 104", out_valid, rd, imm, out_pc); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL skid_ready_reopen got %0b want 1", in_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if ({out_valid, rd, out_pc} !== {1'b1, 5'd3, 32'h108}) $display("FAIL skid_out_c got v=%0b rd=%0d pc=%h want 1 3 108", out_valid, rd, out_pc); else passed++;
        idle_cycle();
        total++; if (out_valid !== 1'b0) $display("FAIL skid_no_dup got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h00100093, 32'h200);
        send(32'h00200113, 32'h204);
        flush = 1'b1;
        send(32'h00700393, 32'h208);
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_state got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else passed++;
        out_ready = 1'b1;
        repeat (3) begin
            idle_cycle();
            total++; if (out_valid !== 1'b0) $display("FAIL flush_leak got v=%0b rd=%0d want v=0", out_valid, rd); else passed++;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        in_valid = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL arst_pre got v=%0b rdy=%0b want 1 0", out_valid, in_ready); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL arst_async got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else passed++;
        total++; if ({rd, imm, out_pc} !== 42'h0) $display("FAIL arst_data got rd=%0d imm=%h pc=%h want 0", rd, imm, out_pc); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            idle_cycle();
            total++; if (out_valid !== 1'b0) $display("FAIL arst_leak got v=%0b rd=%0d want v=0", out_valid, rd); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [4];
        instrs[0] = 32'h00100093;
        instrs[1] = 32'h00200113;
        instrs[2] = 32'h00300193;
        instrs[3] = 32'h00400213;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); else passed++;
            send(instrs[i], 32'h400 + 32'(4 * i));
            total++; if ({out_valid, rd, imm} !== {1'b1, 5'(i + 1), 32'(i + 1)}) $display("FAIL b2b_out[%0d] got v=%0b rd=%0d imm=%h want 1 %0d %0d", i, out_valid, rd, imm, i + 1, i + 1); else passed++;
        end
        idle_cycle();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b want 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_skid();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
